// File: rtl/hazard_pkg.sv
// Shared definitions for the miniLA hazard unit: forwarding-select encodings
// and default register-file geometry.
package hazard_pkg;

    localparam int NREG_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'd0;
    localparam fwd_sel_t FWD_EX  = 2'd1;
    localparam fwd_sel_t FWD_MEM = 2'd2;
    localparam fwd_sel_t FWD_WB  = 2'd3;

endpackage

// File: rtl/hazard_scoreboard.sv
// Long-latency write scoreboard: one busy bit per architectural register plus
// a count of long ops in flight. An accepted issue sets the destination bit;
// a completion clears it only if the bit was actually busy. When both hit the
// same index in one cycle, the set wins.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG      = NREG_DEF,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int MAX_OUTST = 4
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              issue,
    input  logic              issue_set,
    input  logic [REG_AW-1:0] issue_wR,
    input  logic              lu_done,
    input  logic [REG_AW-1:0] lu_wR,
    output logic [NREG-1:0]   sb_busy,
    output logic [3:0]        outst_cnt
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [3:0]      cnt_q;
    logic [3:0]      cnt_d;
    logic            complete;

    // Next busy vector and in-flight count from this cycle's issue and completion.
    always_comb begin
        complete = lu_done && busy_q[lu_wR];
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        if (complete) begin
            busy_d[lu_wR] = 1'b0;
        end
        if (issue && issue_set) begin
            busy_d[issue_wR] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (issue && !complete && (cnt_q < MAX_CNT)) begin
            cnt_d = cnt_q + 4'd1;
        end else if (complete && !issue && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Scoreboard state register with synchronous reset.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sb_busy   = busy_q;
    assign outst_cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard unit for the 5-stage miniLA pipeline: operand forwarding selects,
// load-use / scoreboard / structural stalls and redirect flushes.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall and flush
// performance counters.
module hazard_ctrl_sb
    import hazard_pkg::*;
#(
    parameter int NREG      = NREG_DEF,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int LOAD_LAT  = 1,
    parameter int MAX_OUTST = 4
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_re,
    input  logic              id_rs2_re,
    input  logic [REG_AW-1:0] id_wR,
    input  logic              id_rf_we,
    input  logic              id_is_long,
    input  logic [REG_AW-1:0] ex_wR,
    input  logic [REG_AW-1:0] mem_wR,
    input  logic [REG_AW-1:0] wb_wR,
    input  logic              ex_rf_we,
    input  logic              mem_rf_we,
    input  logic              wb_rf_we,
    input  logic              ex_load,
    input  logic              mem_load,
    input  logic              ex_redirect,
    input  logic              lu_done,
    input  logic [REG_AW-1:0] lu_wR,
    output fwd_sel_t          fwd_rs1_sel,
    output fwd_sel_t          fwd_rs2_sel,
    output logic              pipeline_stop,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [NREG-1:0]   sb_busy,
    output logic [3:0]        outst_cnt
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam logic       LOAD_IN_MEM = (LOAD_LAT == 2);
    localparam logic [3:0] MAX_CNT     = 4'(MAX_OUTST);

    logic ex_m1, mem_m1, wb_m1;
    logic ex_m2, mem_m2, wb_m2;
    logic load_use, raw_stall, waw_stall, struct_stall;
    logic issue, issue_set;

    assign ex_m1  = ex_rf_we  && (ex_wR  != '0) && (ex_wR  == id_rs1) && id_rs1_re;
    assign mem_m1 = mem_rf_we && (mem_wR != '0) && (mem_wR == id_rs1) && id_rs1_re;
    assign wb_m1  = wb_rf_we  && (wb_wR  != '0) && (wb_wR  == id_rs1) && id_rs1_re;
    assign ex_m2  = ex_rf_we  && (ex_wR  != '0) && (ex_wR  == id_rs2) && id_rs2_re;
    assign mem_m2 = mem_rf_we && (mem_wR != '0) && (mem_wR == id_rs2) && id_rs2_re;
    assign wb_m2  = wb_rf_we  && (wb_wR  != '0) && (wb_wR  == id_rs2) && id_rs2_re;

    // Forwarding source per operand, youngest producer first.
    always_comb begin
        fwd_rs1_sel = FWD_RF;
        fwd_rs2_sel = FWD_RF;
        if (ex_m1)       fwd_rs1_sel = FWD_EX;
        else if (mem_m1) fwd_rs1_sel = FWD_MEM;
        else if (wb_m1)  fwd_rs1_sel = FWD_WB;
        if (ex_m2)       fwd_rs2_sel = FWD_EX;
        else if (mem_m2) fwd_rs2_sel = FWD_MEM;
        else if (wb_m2)  fwd_rs2_sel = FWD_WB;
    end

    // Stall causes, merged into one stop that a redirect overrides.
    always_comb begin
        load_use     = id_valid && ((ex_load && (ex_m1 || ex_m2)) ||
                                    (LOAD_IN_MEM && mem_load && (mem_m1 || mem_m2)));
        raw_stall    = id_valid && ((id_rs1_re && sb_busy[id_rs1]) ||
                                    (id_rs2_re && sb_busy[id_rs2]));
        waw_stall    = id_valid && id_rf_we && (id_wR != '0) && sb_busy[id_wR];
        struct_stall = id_valid && id_is_long && (outst_cnt == MAX_CNT);
        pipeline_stop = (load_use || raw_stall || waw_stall || struct_stall) && !ex_redirect;
        issue         = id_valid && id_is_long && !pipeline_stop && !ex_redirect;
        issue_set     = id_rf_we && (id_wR != '0);
    end

    assign flush_if_id = ex_redirect;
    assign flush_id_ex = ex_redirect;

    hazard_scoreboard #(
        .NREG      (NREG),
        .REG_AW    (REG_AW),
        .MAX_OUTST (MAX_OUTST)
    ) u_scoreboard (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .issue     (issue),
        .issue_set (issue_set),
        .issue_wR  (id_wR),
        .lu_done   (lu_done),
        .lu_wR     (lu_wR),
        .sb_busy   (sb_busy),
        .outst_cnt (outst_cnt)
    );

`ifdef HAZ_PERF_CNT_EN
    // Saturating counts of stalled cycles and redirect cycles.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pipeline_stop && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (ex_redirect && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Bench for hazard_ctrl_sb: table of combinational forwarding/stall vectors,
// hand-written multi-cycle scoreboard sequences, then randomized traffic
// compared against a queue-based model of the in-flight long ops.
module tb_hazard_ctrl_sb;

    localparam int MAXO = 2;

    logic       cpu_clk = 1'b0;
    logic       cpu_rst;
    logic       id_valid, id_rs1_re, id_rs2_re, id_rf_we, id_is_long;
    logic [4:0] id_rs1, id_rs2, id_wR, ex_wR, mem_wR, wb_wR, lu_wR;
    logic       ex_rf_we, mem_rf_we, wb_rf_we, ex_load, mem_load, ex_redirect, lu_done;

    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic        pipeline_stop, flush_if_id, flush_id_ex;
    logic [31:0] sb_busy;
    logic [3:0]  outst_cnt;

    logic [1:0]  l2_rs1_sel, l2_rs2_sel;
    logic        l2_stop, l2_flush_if_id, l2_flush_id_ex;
    logic [31:0] l2_sb_busy;
    logic [3:0]  l2_outst_cnt;

    int test_count = 0;
    int fail_count = 0;
    int mq[$];

    always #5 cpu_clk = ~cpu_clk;

    hazard_ctrl_sb #(.NREG(32), .REG_AW(5), .LOAD_LAT(1), .MAX_OUTST(MAXO)) u_dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
        .id_wR(id_wR), .id_rf_we(id_rf_we), .id_is_long(id_is_long),
        .ex_wR(ex_wR), .mem_wR(mem_wR), .wb_wR(wb_wR),
        .ex_rf_we(ex_rf_we), .mem_rf_we(mem_rf_we), .wb_rf_we(wb_rf_we),
        .ex_load(ex_load), .mem_load(mem_load), .ex_redirect(ex_redirect),
        .lu_done(lu_done), .lu_wR(lu_wR),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .pipeline_stop(pipeline_stop), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .sb_busy(sb_busy), .outst_cnt(outst_cnt)
    );

    hazard_ctrl_sb #(.NREG(32), .REG_AW(5), .LOAD_LAT(2), .MAX_OUTST(MAXO)) u_dut_l2 (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
        .id_wR(id_wR), .id_rf_we(id_rf_we), .id_is_long(id_is_long),
        .ex_wR(ex_wR), .mem_wR(mem_wR), .wb_wR(wb_wR),
        .ex_rf_we(ex_rf_we), .mem_rf_we(mem_rf_we), .wb_rf_we(wb_rf_we),
        .ex_load(ex_load), .mem_load(mem_load), .ex_redirect(ex_redirect),
        .lu_done(lu_done), .lu_wR(lu_wR),
        .fwd_rs1_sel(l2_rs1_sel), .fwd_rs2_sel(l2_rs2_sel),
        .pipeline_stop(l2_stop), .flush_if_id(l2_flush_if_id), .flush_id_ex(l2_flush_id_ex),
        .sb_busy(l2_sb_busy), .outst_cnt(l2_outst_cnt)
    );

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       re1, re2, valid;
        logic [4:0] exw;  logic exwe, exld;
        logic [4:0] memw; logic memwe, memld;
        logic [4:0] wbw;  logic wbwe;
        logic       redir;
        logic [1:0] s1, s2;
        logic       stop1, stop2;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        test_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic addVec(input logic [4:0] rs1, rs2, input logic re1, re2, valid,
                          input logic [4:0] exw, input logic exwe, exld,
                          input logic [4:0] memw, input logic memwe, memld,
                          input logic [4:0] wbw, input logic wbwe, redir,
                          input logic [1:0] s1, s2, input logic stop1, stop2);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.re1 = re1; v.re2 = re2; v.valid = valid;
        v.exw = exw; v.exwe = exwe; v.exld = exld;
        v.memw = memw; v.memwe = memwe; v.memld = memld;
        v.wbw = wbw; v.wbwe = wbwe; v.redir = redir;
        v.s1 = s1; v.s2 = s2; v.stop1 = stop1; v.stop2 = stop2;
        vecs.push_back(v);
    endtask

    task automatic clearIn();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_re = 0; id_rs2_re = 0;
        id_wR = 0; id_rf_we = 0; id_is_long = 0;
        ex_wR = 0; mem_wR = 0; wb_wR = 0; ex_rf_we = 0; mem_rf_we = 0; wb_rf_we = 0;
        ex_load = 0; mem_load = 0; ex_redirect = 0; lu_done = 0; lu_wR = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        clearIn();
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_re = v.re1; id_rs2_re = v.re2;
        id_valid = v.valid;
        ex_wR = v.exw; ex_rf_we = v.exwe; ex_load = v.exld;
        mem_wR = v.memw; mem_rf_we = v.memwe; mem_load = v.memld;
        wb_wR = v.wbw; wb_rf_we = v.wbwe; ex_redirect = v.redir;
    endtask

    task automatic longOp(input logic [4:0] wr);
        id_valid = 1; id_is_long = 1; id_rf_we = 1; id_wR = wr;
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge cpu_clk);
    endtask

    function automatic bit m_busy(input int r);
        if (r == 0) return 0;
        foreach (mq[i]) if (mq[i] == r) return 1;
        return 0;
    endfunction

    function automatic logic [1:0] m_sel(input logic [4:0] rs, input logic re);
        if (!re || rs == 0) return 2'd0;
        if (ex_rf_we && ex_wR == rs) return 2'd1;
        if (mem_rf_we && mem_wR == rs) return 2'd2;
        if (wb_rf_we && wb_wR == rs) return 2'd3;
        return 2'd0;
    endfunction

    initial begin
        logic [31:0] exp_busy;
        logic        exp_stop, ldu, any_stall, m_issue, m_comp;
        int          idx;

        clearIn();
        cpu_rst = 1;
        tick();
        tick();
        checkOutput("reset_sb_busy", sb_busy, 32'd0);
        checkOutput("reset_outst_cnt", {28'd0, outst_cnt}, 32'd0);
        cpu_rst = 0;

        //      rs1 rs2 re1 re2 v  exw we ld memw we ld wbw we rd  s1 s2 st1 st2
        addVec(5,  0,  1,  1,  1, 5,  1, 0, 5,   1, 0, 0,  0, 0, 1, 0, 0, 0);
        addVec(0,  0,  1,  1,  1, 5,  1, 0, 5,   1, 0, 0,  0, 0, 0, 0, 0, 0);
        addVec(0,  0,  1,  1,  1, 0,  1, 1, 0,   1, 1, 0,  1, 0, 0, 0, 0, 0);
        addVec(6,  0,  1,  0,  1, 1,  1, 0, 6,   1, 0, 6,  1, 0, 2, 0, 0, 0);
        addVec(0,  9,  0,  1,  1, 8,  1, 0, 10,  1, 0, 9,  1, 0, 0, 3, 0, 0);
        addVec(5,  5,  0,  0,  1, 5,  1, 0, 5,   1, 0, 5,  1, 0, 0, 0, 0, 0);
        addVec(5,  0,  1,  0,  1, 5,  0, 0, 5,   1, 0, 5,  1, 0, 2, 0, 0, 0);
        addVec(0,  7,  0,  1,  1, 7,  1, 1, 0,   0, 0, 0,  0, 0, 0, 1, 1, 1);
        addVec(0,  7,  0,  1,  0, 7,  1, 1, 0,   0, 0, 0,  0, 0, 0, 1, 0, 0);
        addVec(7,  0,  1,  0,  1, 0,  0, 0, 7,   1, 1, 0,  0, 0, 2, 0, 0, 1);
        addVec(0,  7,  0,  1,  1, 7,  1, 1, 0,   0, 0, 0,  0, 1, 0, 1, 0, 0);
        addVec(0,  7,  0,  0,  1, 7,  1, 1, 0,   0, 0, 0,  0, 0, 0, 0, 0, 0);
        addVec(3,  4,  1,  1,  1, 3,  1, 0, 4,   1, 0, 4,  1, 0, 1, 2, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            settle();
            checkOutput($sformatf("vec%0d_rs1_sel", i), {30'd0, fwd_rs1_sel}, {30'd0, vecs[i].s1});
            checkOutput($sformatf("vec%0d_rs2_sel", i), {30'd0, fwd_rs2_sel}, {30'd0, vecs[i].s2});
            checkOutput($sformatf("vec%0d_stop", i), {31'd0, pipeline_stop}, {31'd0, vecs[i].stop1});
            checkOutput($sformatf("vec%0d_stop_lat2", i), {31'd0, l2_stop}, {31'd0, vecs[i].stop2});
            checkOutput($sformatf("vec%0d_flush", i), {30'd0, flush_if_id, flush_id_ex},
                        {30'd0, vecs[i].redir, vecs[i].redir});
            tick();
        end

        // Load-use: one stalled cycle, then the load forwards from MEM.
        clearIn();
        ex_load = 1; ex_wR = 7; ex_rf_we = 1; id_valid = 1; id_rs2 = 7; id_rs2_re = 1;
        settle();
        checkOutput("lu_stop_first", {31'd0, pipeline_stop}, 32'd1);
        tick();
        ex_load = 0; ex_wR = 0; ex_rf_we = 0;
        mem_load = 1; mem_wR = 7; mem_rf_we = 1;
        settle();
        checkOutput("lu_stop_second", {31'd0, pipeline_stop}, 32'd0);
        checkOutput("lu_fwd_mem", {30'd0, fwd_rs2_sel}, 32'd2);
        tick();

        // Redirect beats a load-use stall and suppresses the long issue.
        clearIn();
        longOp(12);
        id_rs1 = 7; id_rs1_re = 1; ex_load = 1; ex_wR = 7; ex_rf_we = 1; ex_redirect = 1;
        settle();
        checkOutput("redir_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
        checkOutput("redir_stop", {31'd0, pipeline_stop}, 32'd0);
        tick();
        clearIn();
        settle();
        checkOutput("redir_sb_busy", sb_busy, 32'd0);
        checkOutput("redir_cnt", {28'd0, outst_cnt}, 32'd0);
        tick();

        // RAW and WAW against an outstanding long write to x9.
        longOp(9);
        settle();
        checkOutput("raw_issue_stop", {31'd0, pipeline_stop}, 32'd0);
        tick();
        clearIn();
        settle();
        checkOutput("raw_busy9_set", sb_busy, 32'h0000_0200);
        checkOutput("raw_cnt1", {28'd0, outst_cnt}, 32'd1);
        id_valid = 1; id_rf_we = 1; id_wR = 9;
        settle();
        checkOutput("waw_stop", {31'd0, pipeline_stop}, 32'd1);
        tick();
        clearIn();
        id_valid = 1; id_rs1 = 9; id_rs1_re = 1;
        for (int c = 0; c < 3; c++) begin
            settle();
            checkOutput($sformatf("raw_stop_c%0d", c), {31'd0, pipeline_stop}, 32'd1);
            tick();
        end
        lu_done = 1; lu_wR = 9;
        settle();
        checkOutput("raw_no_bypass", {31'd0, pipeline_stop}, 32'd1);
        tick();
        lu_done = 0;
        settle();
        checkOutput("raw_released", {31'd0, pipeline_stop}, 32'd0);
        checkOutput("raw_busy9_clr", sb_busy, 32'd0);
        checkOutput("raw_cnt0", {28'd0, outst_cnt}, 32'd0);
        tick();

        // Structural limit with simultaneous issue and completion.
        clearIn(); longOp(3); tick();
        clearIn(); longOp(4); lu_done = 1; lu_wR = 3; tick();
        clearIn();
        settle();
        checkOutput("simul_cnt", {28'd0, outst_cnt}, 32'd1);
        checkOutput("simul_busy", sb_busy, 32'h0000_0010);
        longOp(3); tick();
        clearIn();
        longOp(5);
        settle();
        checkOutput("struct_full_cnt", {28'd0, outst_cnt}, 32'd2);
        checkOutput("struct_stop", {31'd0, pipeline_stop}, 32'd1);
        tick();
        lu_done = 1; lu_wR = 3;
        settle();
        checkOutput("struct_stop_with_done", {31'd0, pipeline_stop}, 32'd1);
        tick();
        lu_done = 0;
        settle();
        checkOutput("struct_retry_stop", {31'd0, pipeline_stop}, 32'd0);
        checkOutput("struct_cnt_after_done", {28'd0, outst_cnt}, 32'd1);
        tick();
        clearIn();
        settle();
        checkOutput("struct_cnt_final", {28'd0, outst_cnt}, 32'd2);
        checkOutput("struct_busy_final", sb_busy, 32'h0000_0030);

        // Mid-operation reset, then spurious completions and x0 destinations.
        cpu_rst = 1; tick(); cpu_rst = 0;
        settle();
        checkOutput("rst_sb_busy", sb_busy, 32'd0);
        checkOutput("rst_cnt", {28'd0, outst_cnt}, 32'd0);
        lu_done = 1; lu_wR = 4; tick(); clearIn();
        settle();
        checkOutput("spurious_cnt", {28'd0, outst_cnt}, 32'd0);
        checkOutput("spurious_busy", sb_busy, 32'd0);
        longOp(0); tick(); clearIn();
        lu_done = 1; lu_wR = 0; tick(); clearIn();
        settle();
        checkOutput("x0_cnt", {28'd0, outst_cnt}, 32'd1);
        checkOutput("x0_busy", sb_busy, 32'd0);
        cpu_rst = 1; tick(); cpu_rst = 0;

        // Randomized traffic against the in-flight queue model.
        mq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cpu_rst     = ($urandom_range(0, 99) == 0);
            id_valid    = ($urandom_range(0, 4) != 0);
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rs1_re   = ($urandom_range(0, 3) != 0);
            id_rs2_re   = ($urandom_range(0, 3) != 0);
            id_wR       = 5'($urandom_range(0, 7));
            id_rf_we    = ($urandom_range(0, 7) != 0);
            id_is_long  = ($urandom_range(0, 2) == 0);
            ex_wR       = 5'($urandom_range(0, 7));
            mem_wR      = 5'($urandom_range(0, 7));
            wb_wR       = 5'($urandom_range(0, 7));
            ex_rf_we    = ($urandom_range(0, 1) == 0);
            mem_rf_we   = ($urandom_range(0, 1) == 0);
            wb_rf_we    = ($urandom_range(0, 1) == 0);
            ex_load     = ($urandom_range(0, 3) == 0);
            mem_load    = ($urandom_range(0, 3) == 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            lu_done     = ($urandom_range(0, 3) == 0);
            if (mq.size() > 0 && $urandom_range(0, 1) == 0) begin
                idx   = $urandom_range(0, mq.size() - 1);
                lu_wR = 5'(mq[idx]);
            end else begin
                lu_wR = 5'($urandom_range(0, 7));
            end

            exp_busy = 32'd0;
            foreach (mq[i]) if (mq[i] != 0) exp_busy[mq[i]] = 1'b1;
            ldu = ex_load && ((m_sel(id_rs1, id_rs1_re) == 2'd1) || (m_sel(id_rs2, id_rs2_re) == 2'd1));
            any_stall = ldu ||
                        (id_rs1_re && m_busy(int'(id_rs1))) ||
                        (id_rs2_re && m_busy(int'(id_rs2))) ||
                        (id_rf_we && m_busy(int'(id_wR))) ||
                        (id_is_long && mq.size() == MAXO);
            exp_stop = id_valid && any_stall && !ex_redirect;
            m_issue  = id_valid && id_is_long && !exp_stop && !ex_redirect;
            m_comp   = lu_done && m_busy(int'(lu_wR));

            settle();
            checkOutput("rnd_rs1_sel", {30'd0, fwd_rs1_sel}, {30'd0, m_sel(id_rs1, id_rs1_re)});
            checkOutput("rnd_rs2_sel", {30'd0, fwd_rs2_sel}, {30'd0, m_sel(id_rs2, id_rs2_re)});
            checkOutput("rnd_stop", {31'd0, pipeline_stop}, {31'd0, exp_stop});
            checkOutput("rnd_flush", {30'd0, flush_if_id, flush_id_ex}, {30'd0, ex_redirect, ex_redirect});
            checkOutput("rnd_sb_busy", sb_busy, exp_busy);
            checkOutput("rnd_cnt", {28'd0, outst_cnt}, 32'(mq.size()));

            @(posedge cpu_clk);
            if (cpu_rst) begin
                mq.delete();
            end else begin
                if (m_comp) begin
                    foreach (mq[i]) begin
                        if (mq[i] == int'(lu_wR)) begin
                            mq.delete(i);
                            break;
                        end
                    end
                end
                if (m_issue) mq.push_back((id_rf_we && id_wR != 0) ? int'(id_wR) : 0);
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
